// File: rtl/fsk_uart_rx.sv
// FSK demodulating UART receiver: classifies the upstream carrier period into mark/space,
// debounces the level, and frames 8N1 bytes sampled mid-bit.
module fsk_uart_rx #(
  parameter int SAMPLES_PER_BIT = 1000,
  parameter int PERIOD_THRESH   = 40,
  parameter int PERIOD_MAX      = 200,
  parameter int FILT_LEN        = 4
) (
  input  logic        sample_clk,
  input  logic        rst,
  input  logic [15:0] period_in,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        carrier_ok,
  output logic        bit_level
);

  localparam logic [15:0] HALF_LAST = 16'(SAMPLES_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(SAMPLES_PER_BIT - 1);
  localparam logic [15:0] THRESH    = 16'(PERIOD_THRESH);
  localparam logic [15:0] PMAX      = 16'(PERIOD_MAX);
  localparam logic [3:0]  FILT_LAST = 4'(FILT_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  logic        raw_p0;
  logic        carrier_p0;
  logic [3:0]  filt_cnt;
  logic        level_prev;
  logic        fall_edge;
  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;

  assign raw_p0     = (period_in <= THRESH);
  assign carrier_p0 = (period_in != 16'd0) && (period_in <= PMAX);
  assign fall_edge  = level_prev & ~bit_level;

  // Stage 1: carrier detect and glitch filter; the filter freezes while no carrier is present
  always_ff @(posedge sample_clk) begin
    if (!rst) begin
      carrier_ok <= 1'b0;
      filt_cnt   <= 4'd0;
      bit_level  <= 1'b1;
      level_prev <= 1'b1;
    end else begin
      carrier_ok <= carrier_p0;
      level_prev <= bit_level;
      if (carrier_ok) begin
        if (raw_p0 == bit_level) begin
          filt_cnt <= 4'd0;
        end else if (filt_cnt == FILT_LAST) begin
          bit_level <= ~bit_level;
          filt_cnt  <= 4'd0;
        end else begin
          filt_cnt <= filt_cnt + 4'd1;
        end
      end
    end
  end

  // Stage 2: framing FSM, samples the filtered level mid-bit with no resync inside a frame
  always_ff @(posedge sample_clk) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= 16'd0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= 16'd0;
          bit_idx  <= 3'd0;
          if (fall_edge && carrier_ok) begin
            state <= START;
          end
        end
        START: begin
          if (!carrier_ok) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
          end else if (baud_cnt == HALF_LAST) begin
            baud_cnt <= 16'd0;
            state    <= bit_level ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (!carrier_ok) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            frame_err <= 1'b1;
          end else if (baud_cnt == BIT_LAST) begin
            shift_reg <= {bit_level, shift_reg[7:1]};
            baud_cnt  <= 16'd0;
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (!carrier_ok) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            frame_err <= 1'b1;
          end else if (baud_cnt == BIT_LAST) begin
            baud_cnt <= 16'd0;
            if (bit_level) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        BREAK: begin
          // Wait out a held-low line so it cannot look like a fresh start bit
          baud_cnt <= 16'd0;
          if (bit_level) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_uart_rx.sv
// Scoreboard bench for fsk_uart_rx: stimulus pushes expected pulses, a monitor pops on each pulse.
module tb_fsk_uart_rx;

  localparam int          SPB   = 16;
  localparam logic [15:0] MARK  = 16'd20;
  localparam logic [15:0] SPACE = 16'd60;
  // Start-bit drive to stop-bit sample edge: 2 filter + 1 edge detect + 8 half bit + 9*16
  localparam int          STOP_LAT = 155;

  logic        sample_clk = 1'b0;
  logic        rst        = 1'b0;
  logic [15:0] period_in  = MARK;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        carrier_ok;
  logic        bit_level;

  fsk_uart_rx #(
    .SAMPLES_PER_BIT(SPB),
    .PERIOD_THRESH  (40),
    .PERIOD_MAX     (200),
    .FILT_LEN       (2)
  ) dut (
    .sample_clk(sample_clk),
    .rst       (rst),
    .period_in (period_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .carrier_ok(carrier_ok),
    .bit_level (bit_level)
  );

  always #5 sample_clk = ~sample_clk;

  int cyc = 0;
  always @(posedge sample_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge sample_clk) begin : monitor
    exp_t e;
    if (rx_valid === 1'b1 || frame_err === 1'b1) begin
      chk("pulse_exclusive", 32'(rx_valid & frame_err), 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: actual valid=%b err=%b at cyc %0d, required no pulse",
                 rx_valid, frame_err, cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
        chk("rx_data", 32'(rx_data), 32'(e.data));
        chk("pulse_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic hold(input logic [15:0] p, input int n);
    period_in = p;
    repeat (n) begin
      @(posedge sample_clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_mark, input int stop_len);
    int n;
    n = cyc;
    if (stop_mark) begin
      sb.push_back('{is_err: 1'b0, data: b, at: n + STOP_LAT});
    end else begin
      sb.push_back('{is_err: 1'b1, data: last_good, at: n + STOP_LAT});
    end
    hold(SPACE, SPB);
    for (int i = 0; i < 8; i++) hold(b[i] ? MARK : SPACE, SPB);
    hold(stop_mark ? MARK : SPACE, stop_len);
    if (stop_mark) last_good = b;
    hold(MARK, 30);
  endtask

  task automatic check_reset_outputs();
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_carrier_ok", 32'(carrier_ok), 32'd0);
    chk("rst_bit_level", 32'(bit_level), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    logic [7:0] b;
    repeat (3) @(posedge sample_clk);
    #1;
    check_reset_outputs();
    rst = 1'b1;
    hold(MARK, 1);
    chk("carrier_rise", 32'(carrier_ok), 32'd1);
    hold(MARK, 20);
    chk("idle_level", 32'(bit_level), 32'd1);

    // Good frame
    send_byte(8'hA5, 1'b1, SPB);

    // False start: short space, mid-start sample sees mark
    hold(SPACE, 6);
    hold(MARK, 30);
    chk("false_start_rx_data", 32'(rx_data), 32'hA5);

    // Stop bit as space, then held-low line
    send_byte(8'h3C, 1'b0, SPB + 40);
    chk("after_break_rx_data", 32'(rx_data), 32'hA5);

    // Carrier loss in the middle of data bit 3 of 0x5A
    b = 8'h5A;
    n = cyc;
    sb.push_back('{is_err: 1'b1, data: last_good, at: n + 74});
    hold(SPACE, SPB);
    for (int i = 0; i < 3; i++) hold(b[i] ? MARK : SPACE, SPB);
    hold(MARK, 8);
    hold(16'd0, 1);
    chk("carrier_fall", 32'(carrier_ok), 32'd0);
    hold(16'd0, 19);
    hold(MARK, 30);
    chk("carrier_back", 32'(carrier_ok), 32'd1);

    // Single-cycle space glitches every 5 cycles
    for (int i = 0; i < 10; i++) begin
      hold(SPACE, 1);
      hold(MARK, 4);
      chk("glitch_level", 32'(bit_level), 32'd1);
    end

    // Reset pulse in data bit 5 of 0x3C discards the frame
    b = 8'h3C;
    hold(SPACE, SPB);
    for (int i = 0; i < 5; i++) hold(b[i] ? MARK : SPACE, SPB);
    hold(b[5] ? MARK : SPACE, 4);
    rst = 1'b0;
    period_in = MARK;
    @(posedge sample_clk);
    #1;
    check_reset_outputs();
    rst = 1'b1;
    last_good = 8'h00;
    hold(MARK, 30);
    send_byte(8'h81, 1'b1, SPB);
    chk("final_rx_data", 32'(rx_data), 32'h81);

    hold(MARK, 20);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
